audiodac_sinemon: RTL and testbench



---
 rtl/audiodac_pkg.sv | 13 +
 rtl/audiodac_sinemon_div.sv | 28 ++
 rtl/audiodac_sinemon.sv | 121 ++++++++++++
 tb/tb_audiodac_sinemon.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audiodac_pkg.sv
// audiodac shared types: sample-monitor crossing states
// and default sample width.
package audiodac_pkg;

  localparam int BW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2
  } mon_state_e;

endpackage

// File: rtl/audiodac_sinemon_div.sv
// audiodac_sinemon_div: read-rate divider, one strobe
// every div_i+1 enabled cycles.
module audiodac_sinemon_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             rd_o
);

  logic [DIV_W-1:0] div_cnt;

  // >= so a lowered setting strobes on the next cycle
  assign rd_o = en_i && (div_cnt >= div_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt <= '0;
    end else if (!en_i || rd_o) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/audiodac_sinemon.sv
// audiodac_sinemon: paced sample consumer tracking peaks and
// the period between rising zero crossings.
module audiodac_sinemon
  import audiodac_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int DIV_W = 8,
  parameter int PER_W = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic signed [BW-1:0]    data_i,
  output logic                    data_rd_o,
  input  logic                    mon_en_i,
  input  logic [DIV_W-1:0]        mon_div_i,
  input  logic                    mon_clr_i,
  output logic signed [BW-1:0]    peak_pos_o,
  output logic signed [BW-1:0]    peak_neg_o,
  output logic [PER_W-1:0]        period_o,
  output logic                    period_vld_o
);

  localparam logic [PER_W-1:0] PER_MAX = '1;

  mon_state_e state_q, state_d;

  logic                 cap;
  logic                 s_neg;
  logic                 rise;
  logic                 have_ref_q;
  logic signed [BW-1:0] peak_pos_q;
  logic signed [BW-1:0] peak_neg_q;
  logic [PER_W-1:0]     per_cnt_q;
  logic [PER_W-1:0]     per_inc;
  logic [PER_W-1:0]     period_q;
  logic                 period_vld_q;

  audiodac_sinemon_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (mon_en_i),
    .div_i   (mon_div_i),
    .rd_o    (cap)
  );

  assign data_rd_o    = cap;
  assign s_neg        = data_i[BW-1];
  assign per_inc      = (per_cnt_q == PER_MAX) ?
                        PER_MAX : per_cnt_q + PER_W'(1);
  assign peak_pos_o   = peak_pos_q;
  assign peak_neg_o   = peak_neg_q;
  assign period_o     = period_q;
  assign period_vld_o = period_vld_q;

  always_comb begin
    state_d = state_q;
    rise    = 1'b0;
    if (mon_clr_i || !mon_en_i) begin
      state_d = IDLE;
    end else if (cap) begin
      unique case (state_q)
        IDLE: state_d = s_neg ? NEG : POS;
        POS:  if (s_neg) state_d = NEG;
        NEG: begin
          if (!s_neg) begin
            state_d = POS;
            rise    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      peak_pos_q   <= '0;
      peak_neg_q   <= '0;
      per_cnt_q    <= '0;
      have_ref_q   <= 1'b0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
    end else begin
      period_vld_q <= 1'b0;
      if (mon_clr_i) begin
        peak_pos_q <= '0;
        peak_neg_q <= '0;
        per_cnt_q  <= '0;
        have_ref_q <= 1'b0;
      end else if (!mon_en_i) begin
        per_cnt_q  <= '0;
        have_ref_q <= 1'b0;
      end else if (cap) begin
        if (data_i > peak_pos_q) peak_pos_q <= data_i;
        if (data_i < peak_neg_q) peak_neg_q <= data_i;
        if (rise) begin
          // first crossing after idle/clear is the reference only
          per_cnt_q  <= '0;
          have_ref_q <= 1'b1;
          if (have_ref_q) begin
            period_q     <= per_inc;
            period_vld_q <= 1'b1;
          end
        end else begin
          per_cnt_q <= per_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_audiodac_sinemon.sv
// tb_audiodac_sinemon: random and directed stimulus checked
// against a sample-history reference model.
module tb_audiodac_sinemon;
  import audiodac_pkg::*;

  localparam int BW    = 16;
  localparam int DIV_W = 8;
  localparam int PER_W = 10;
  localparam int PMAX  = 1023;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i = 1'b0;
  logic signed [BW-1:0] data_i;
  logic                 data_rd_o;
  logic                 mon_en_i;
  logic [DIV_W-1:0]     mon_div_i;
  logic                 mon_clr_i;
  logic signed [BW-1:0] peak_pos_o;
  logic signed [BW-1:0] peak_neg_o;
  logic [PER_W-1:0]     period_o;
  logic                 period_vld_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  audiodac_sinemon #(
    .BW    (BW),
    .DIV_W (DIV_W),
    .PER_W (PER_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .data_i       (data_i),
    .data_rd_o    (data_rd_o),
    .mon_en_i     (mon_en_i),
    .mon_div_i    (mon_div_i),
    .mon_clr_i    (mon_clr_i),
    .peak_pos_o   (peak_pos_o),
    .peak_neg_o   (peak_neg_o),
    .period_o     (period_o),
    .period_vld_o (period_vld_o)
  );

  // reference model state
  int cyc;
  int anchor;
  int pk_pos, pk_neg;
  int seg[$];
  int xs[$];
  int exp_per;
  bit exp_vld;
  bit use_sine;
  int idx, stp;
  int lut[64];
  int nstrobe, nvld;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic bit pred_rd();
    return mon_en_i && ((cyc - anchor) >= int'(mon_div_i));
  endfunction

  task automatic model_reset();
    pk_pos  = 0;
    pk_neg  = 0;
    seg.delete();
    xs.delete();
    exp_per = 0;
    exp_vld = 0;
  endtask

  task automatic cycle();
    bit rd;
    int s, n, d;
    if (use_sine) data_i = 16'(lut[idx]);
    #1;
    rd = pred_rd();
    chk("rd", data_rd_o, rd);
    s = data_i;
    @(posedge clk_i);
    if (rd || !mon_en_i) anchor = cyc + 1;
    cyc++;
    exp_vld = 0;
    if (mon_clr_i) begin
      pk_pos = 0;
      pk_neg = 0;
      seg.delete();
      xs.delete();
    end else if (!mon_en_i) begin
      seg.delete();
      xs.delete();
    end else if (rd) begin
      if (s > pk_pos) pk_pos = s;
      if (s < pk_neg) pk_neg = s;
      seg.push_back(s);
      n = seg.size();
      if (n >= 2 && seg[n-2] < 0 && s >= 0) begin
        xs.push_back(n - 1);
        if (xs.size() >= 2) begin
          d = xs[xs.size()-1] - xs[xs.size()-2];
          exp_per = (d > PMAX) ? PMAX : d;
          exp_vld = 1;
        end
      end
    end
    if (rd) nstrobe++;
    if (rd && use_sine) idx = (idx + stp) % 64;
    #1;
    chk("pk_pos", peak_pos_o, pk_pos);
    chk("pk_neg", peak_neg_o, pk_neg);
    chk("vld", period_vld_o, exp_vld);
    chk("per", period_o, exp_per);
    if (period_vld_o) nvld++;
    @(negedge clk_i);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"}, data_rd_o, 0);
    chk({tag, "_pp"}, peak_pos_o, 0);
    chk({tag, "_pn"}, peak_neg_o, 0);
    chk({tag, "_per"}, period_o, 0);
    chk({tag, "_vld"}, period_vld_o, 0);
  endtask

  task automatic clr_cycle();
    mon_clr_i = 1'b1;
    cycle();
    mon_clr_i = 1'b0;
  endtask

  initial begin
    int k, tmp, first;
    real v;
    for (int i = 0; i < 64; i++) begin
      v = 0.9 * 32767.0 * $sin(2.0 * 3.14159265358979 * i / 64.0);
      lut[i] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    end
    mon_en_i  = 1'b0;
    mon_clr_i = 1'b0;
    mon_div_i = 8'd3;
    data_i    = '0;
    use_sine  = 0;
    idx = 0;
    stp = 1;
    cyc = 0;
    model_reset();
    #3;
    chk_zero("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    anchor  = cyc;

    // strobe rate
    mon_en_i = 1'b1;
    nstrobe  = 0;
    repeat (40) cycle();
    chk("n_div3", nstrobe, 10);
    mon_div_i = 8'd0;
    nstrobe   = 0;
    repeat (8) cycle();
    chk("n_div0", nstrobe, 8);
    mon_div_i = 8'd6;
    repeat (3) cycle();
    mon_div_i = 8'd1;
    repeat (4) cycle();

    // sine, step 1 then 2 then 4
    clr_cycle();
    use_sine  = 1;
    idx       = 0;
    stp       = 1;
    mon_div_i = 8'd1;
    nvld      = 0;
    repeat (520) cycle();
    chk("sine1_per", period_o, 64);
    chk("sine1_pp", peak_pos_o, 29490);
    chk("sine1_pn", peak_neg_o, -29490);
    chk("sine1_nvld", nvld >= 2, 1);
    stp = 2;
    repeat (300) cycle();
    chk("sine2_per", period_o, 32);
    stp = 4;
    repeat (200) cycle();
    chk("sine4_per", period_o, 16);

    // period overflow
    use_sine  = 0;
    mon_div_i = 8'd0;
    clr_cycle();
    data_i = -16'sd5;
    repeat (5) cycle();
    data_i = 16'sd1;
    cycle();
    data_i = -16'sd5;
    repeat (1100) cycle();
    data_i = 16'sd1;
    cycle();
    chk("ovf_vld", period_vld_o, 1);
    chk("ovf_per", period_o, PMAX);

    // clear colliding with a capture
    mon_div_i = 8'd2;
    data_i    = -16'sd100;
    k = 0;
    while (!pred_rd() && k < 10) begin
      cycle();
      k++;
    end
    chk("clr_find_strobe", pred_rd(), 1);
    data_i = 16'sd30000;
    clr_cycle();
    chk("clr_pp", peak_pos_o, 0);
    chk("clr_pn", peak_neg_o, 0);
    nvld = 0;
    data_i = -16'sd100;
    repeat (6) cycle();
    data_i = 16'sd200;
    repeat (3) cycle();
    chk("clr_ref_only", nvld, 0);
    data_i = -16'sd100;
    repeat (6) cycle();
    data_i = 16'sd200;
    repeat (3) cycle();
    chk("clr_then_per", nvld, 1);

    // asynchronous reset mid-interval
    mon_div_i = 8'd3;
    data_i    = 16'sd50;
    repeat (2) cycle();
    #2 rst_n_i = 1'b0;
    #1;
    chk_zero("arst");
    model_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    anchor  = cyc;
    nstrobe = 0;
    first   = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (nstrobe == 1 && first == 0) first = i;
    end
    chk("arst_first", first, 4);

    // randomized mix
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        use_sine = $urandom_range(0, 1);
        stp = $urandom_range(1, 8);
      end
      if ($urandom_range(0, 99) == 0)
        mon_div_i = 8'($urandom_range(0, 4));
      mon_en_i  = ($urandom_range(0, 39) != 0);
      mon_clr_i = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1) == 1) begin
        data_i = 16'($urandom);
      end else begin
        tmp = int'($urandom_range(0, 40)) - 20;
        data_i = 16'(tmp);
      end
      cycle();
    end
    mon_clr_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
